lfsr_gen: RTL
=============

# lfsr_gen

Parametrised linear-feedback shift register generator, the successor to the fixed 5-bit Fibonacci LFSR. It supports any width, a per-instance tap mask and either Fibonacci or Galois form. It also adds a step enable, seed loading independent of reset, all-zero lockup detection and automatic measurement of the sequence period. It sits beside test-pattern and scrambler logic as the shared pseudo-random source.

## Interface
Parameters:
- WIDTH, 5, register width in bits (≥ 2).
- TAPS, 5'b10100, WIDTH-bit tap mask. Its meaning depends on MODE.
- MODE, 0, 0 = Fibonacci, 1 = Galois.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed  in  WIDTH  value captured on load.
- load  in  1  load seed into the register.
- en  in  1  advance one step.
- data  out  WIDTH  current LFSR state (registered).
- valid  out  1  data holds a sequence state from a non-zero load.
- lockup  out  1  last load was all-zero; stepping is blocked.
- wrap  out  1  one-cycle pulse when the state returns to the loaded seed.
- period  out  WIDTH  steps from load to the first return to seed.
- period_valid  out  1  period holds a measured value.

## Operation
- Priority per cycle: rst > load > en.
- rst: sets data=0, valid=0, lockup=0, wrap=0, period=0, period_valid=0, internal step count=0, stored seed=0.
- load with seed≠0:
  - data=seed, stored seed=seed, valid=1, lockup=0.
  - count=0, period_valid=0, period=0, wrap=0.
- load with seed=0:
  - data=0, valid=0, lockup=1.
  - count, period and period_valid cleared as for a non-zero load.
- Step condition: en=1, valid=1, no rst, no load. With en=1 and valid=0 the register holds and no outputs change; this covers both lockup and the state after reset.
- Fibonacci step (MODE=0):
  - fb = XOR reduction of (data & TAPS).
  - data ← {data[WIDTH-2:0], fb}.
- Galois step (MODE=1):
  - data ← {data[WIDTH-2:0], 1'b0} ^ ({WIDTH{data[WIDTH-1]}} & TAPS).
- Step count: increments on each step and saturates at all-ones.
- Return to seed: when the next state equals the stored seed, then on that edge:
  - wrap=1 for exactly one cycle;
  - period = count+1, saturated;
  - period_valid=1.
  - count restarts at 0.
- Later returns pulse wrap again and re-latch period; the value is the same for a deterministic sequence.
- Saturation: if count saturates before any return, period_valid stays 0 until a return occurs.

## Timing
- All outputs are registered. Latency from a load or step request to new data is 1 cycle.
- wrap, period and period_valid update on the same edge that places the seed back on data.
- Holding en high advances one step per clock, with no bubbles.
- load together with en in the same cycle: the load wins and no step occurs.
- rst in the middle of a sequence: the next cycle shows the full reset state. Stepping does not resume until a non-zero load.
- Outside rst and load, the only way to reach the all-zero state is a non-maximal TAPS setting. The block does not detect that case; lockup is asserted only by a load of zero.

## Test plan
- Fibonacci, WIDTH=5, TAPS=5'b10100: rst, then load seed=5'b00111, then en held high.
  - Required data after the load: 00111, 01111, 11111, 11110, 11100, 11000, 10001.
- Same configuration, en held high for 31 steps:
  - wrap pulses exactly on step 31 with data=00111.
  - period=31, period_valid=1.
  - No wrap before step 31; wrap pulses again at step 62.
- Galois, MODE=1, TAPS=5'b00101, seed=5'b00111:
  - Required data: 01110, 11100, 11101, 11111.
  - period=31 after the first return to seed.
- Load seed=0 with en high:
  - lockup=1, valid=0, data stays 0 for 10 cycles, no wrap pulse.
  - A following load of 5'b00001 gives lockup=0, valid=1, and stepping resumes.
- Priority checks:
  - load and en in the same cycle leave data=seed.
  - rst and load in the same cycle give data=0, valid=0.
  - rst asserted mid-sequence gives every output its reset value on the next cycle.
- en toggled every other cycle:
  - The sequence matches the first scenario with each state held for 2 cycles.
  - period is still 31, counting steps rather than clocks.

Source files
------------

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, step enable, all-zero
// lockup flag and automatic measurement of the sequence period.
module lfsr_gen #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = 5'b10100,
  parameter int              MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_lockup;
  logic             r_wrap;
  logic             r_period_valid;

  logic [WIDTH-1:0] w_next;
  logic             w_fb;
  logic             w_step;
  logic             w_return;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_comb begin
    w_fb = ^(r_data & TAPS);
    if (MODE == 0)
      w_next = {r_data[WIDTH-2:0], w_fb};
    else
      w_next = {r_data[WIDTH-2:0], 1'b0} ^ ({WIDTH{r_data[WIDTH-1]}} & TAPS);
  end

  // A zero load leaves valid low, so lockup blocks stepping without extra logic.
  assign w_step   = en && r_valid;
  assign w_return = (w_next == r_seed);

  // State, step count and period measurement
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data         <= '0;
      r_seed         <= '0;
      r_count        <= '0;
      r_period       <= '0;
      r_valid        <= 1'b0;
      r_lockup       <= 1'b0;
      r_wrap         <= 1'b0;
      r_period_valid <= 1'b0;
    end else if (load) begin
      r_data         <= seed;
      r_seed         <= seed;
      r_count        <= '0;
      r_period       <= '0;
      r_valid        <= |seed;
      r_lockup       <= ~|seed;
      r_wrap         <= 1'b0;
      r_period_valid <= 1'b0;
    end else if (w_step) begin
      r_data <= w_next;
      if (w_return) begin
        r_wrap         <= 1'b1;
        r_period       <= sat_inc(r_count);
        r_period_valid <= 1'b1;
        r_count        <= '0;
      end else begin
        r_wrap  <= 1'b0;
        r_count <= sat_inc(r_count);
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign data         = r_data;
  assign valid        = r_valid;
  assign lockup       = r_lockup;
  assign wrap         = r_wrap;
  assign period       = r_period;
  assign period_valid = r_period_valid;

endmodule
